// File: rtl/mem_word_port.sv
// -----------------------------------------------------------------------------
// mem_word_port
//
// Word-to-byte memory adapter. The core presents one word read or word write
// through a valid/ready handshake. The adapter then runs WORD_BYTES consecutive
// byte beats on a narrow memory bus, starting at the request's base address.
//  - Reads assemble the returned bytes into a word using the selected byte
//    order. The word is reported with a one-cycle completion pulse.
//  - Writes send the latched word out one byte per beat, in the same order.
//
// Parameters
//   ADDR_WIDTH  byte address width of the memory bus and the request address
//   BYTE_WIDTH  width of one memory beat
//   WORD_BYTES  beats per word (>= 1)
//   BIG_ENDIAN  0: byte at base+i lands in lane i
//               1: byte at base+i lands in lane WORD_BYTES-1-i
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_ready   adapter can accept a request this cycle
//   req_write   1 = word write, 0 = word read
//   req_addr    base byte address
//   req_wdata   word to write
//   resp_valid  one-cycle completion pulse (read data valid / write done)
//   resp_rdata  last assembled read word; held until the next read completes
//   busy        high while beats are in progress
//   adr         memory byte address
//   memwrite    memory write strobe
//   writedata   memory write byte
//   memdata     memory read byte; combinational from adr in the same cycle
//
// Timing: a request accepted at edge k occupies beat cycles k+1..k+WORD_BYTES.
// resp_valid is high in cycle k+WORD_BYTES+1, and the next request can be
// accepted at edge k+WORD_BYTES+2. Every output comes straight from a register.
// -----------------------------------------------------------------------------
module mem_word_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [BYTE_WIDTH*WORD_BYTES-1:0] req_wdata,
  output logic                             resp_valid,
  output logic [BYTE_WIDTH*WORD_BYTES-1:0] resp_rdata,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            adr,
  output logic                             memwrite,
  output logic [BYTE_WIDTH-1:0]            writedata,
  input  logic [BYTE_WIDTH-1:0]            memdata
);

  localparam int WORD_WIDTH = BYTE_WIDTH * WORD_BYTES;
  // The beat counter must hold WORD_BYTES-1, and it is at least one bit wide.
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [CW-1:0]           beat_reg;
  logic [WORD_WIDTH-1:0]   wdata_reg;      // latched write word
  logic [WORD_WIDTH-1:0]   asm_reg;        // read word under assembly
  logic [WORD_WIDTH-1:0]   rdata_reg;      // word reported on resp_rdata
  logic                    ready_reg;
  logic                    resp_valid_reg;
  logic                    busy_reg;
  logic [ADDR_WIDTH-1:0]   adr_reg;
  logic                    memwrite_reg;
  logic [BYTE_WIDTH-1:0]   writedata_reg;

  // Maps a beat number to the word lane it reads into or writes from.
  function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] beat);
    if (BIG_ENDIAN != 0) begin
      return LAST_BEAT - beat;
    end else begin
      return beat;
    end
  endfunction

  logic [CW-1:0] beat_inc;
  logic [CW-1:0] lane_cur;
  logic [CW-1:0] lane_nxt;
  logic [CW-1:0] lane_first;
  logic          last_beat;

  assign beat_inc   = beat_reg + CW'(1);
  assign lane_cur   = lane_of(beat_reg);
  assign lane_nxt   = lane_of(beat_inc);
  assign lane_first = lane_of('0);
  assign last_beat  = (beat_reg == LAST_BEAT);

  // Lane views of the incoming and latched write words. The next assembled
  // word is the current one with the beat's lane replaced by memdata.
  logic [BYTE_WIDTH-1:0] req_lanes   [WORD_BYTES];
  logic [BYTE_WIDTH-1:0] wdata_lanes [WORD_BYTES];
  logic [WORD_WIDTH-1:0] asm_next;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign req_lanes[gi]   = req_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
      assign wdata_lanes[gi] = wdata_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
      assign asm_next[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        (lane_cur == CW'(gi)) ? memdata : asm_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      wdata_reg      <= '0;
      asm_reg        <= '0;
      rdata_reg      <= '0;
      ready_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      adr_reg        <= '0;
      memwrite_reg   <= 1'b0;
      writedata_reg  <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // ready rises one cycle after reset release. From then on it is
          // high for the whole of IDLE.
          ready_reg <= 1'b1;
          if (req_valid && ready_reg) begin
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            beat_reg  <= '0;
            adr_reg   <= req_addr;
            wdata_reg <= req_wdata;
            if (req_write) begin
              state_reg     <= WRITE;
              memwrite_reg  <= 1'b1;
              writedata_reg <= req_lanes[lane_first];
            end else begin
              state_reg <= READ;
            end
          end
        end

        READ: begin
          asm_reg <= asm_next;
          if (last_beat) begin
            rdata_reg      <= asm_next;
            resp_valid_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= DONE;
          end else begin
            beat_reg <= beat_inc;
            adr_reg  <= adr_reg + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
          end
        end

        WRITE: begin
          if (last_beat) begin
            memwrite_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= DONE;
          end else begin
            beat_reg      <= beat_inc;
            adr_reg       <= adr_reg + ADDR_WIDTH'(1);
            writedata_reg <= wdata_lanes[lane_nxt];
          end
        end

        DONE: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign busy       = busy_reg;
  assign adr        = adr_reg;
  assign memwrite   = memwrite_reg;
  assign writedata  = writedata_reg;

endmodule

// File: tb/tb_mem_word_port.sv
// -----------------------------------------------------------------------------
// tb_mem_word_port
//
// Drives a little-endian and a big-endian instance of mem_word_port with the
// same request stream. Each instance has its own byte memory. A reference copy
// of each memory is updated from the requested transactions. The bench uses it
// to predict read words and per-beat write bytes.
// -----------------------------------------------------------------------------
module tb_mem_word_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;

  logic [1:0]  ready_v;
  logic [1:0]  resp_valid_v;
  logic [1:0]  busy_v;
  logic [1:0]  memwrite_v;
  logic [31:0] rdata_v     [2];
  logic [7:0]  adr_v       [2];
  logic [7:0]  writedata_v [2];
  logic [7:0]  memdata_v   [2];

  logic [7:0]  mem     [2][256];   // memory seen by each instance
  logic [7:0]  ref_mem [2][256];   // expected memory contents
  logic [31:0] last_rd [2];        // expected resp_rdata

  int checks = 0;
  int errors = 0;

  assign memdata_v[0] = mem[0][adr_v[0]];
  assign memdata_v[1] = mem[1][adr_v[1]];

  mem_word_port #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(ready_v[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_v[0]), .resp_rdata(rdata_v[0]), .busy(busy_v[0]),
    .adr(adr_v[0]), .memwrite(memwrite_v[0]), .writedata(writedata_v[0]),
    .memdata(memdata_v[0])
  );

  mem_word_port #(.BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(ready_v[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_v[1]), .resp_rdata(rdata_v[1]), .busy(busy_v[1]),
    .adr(adr_v[1]), .memwrite(memwrite_v[1]), .writedata(writedata_v[1]),
    .memdata(memdata_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane that byte i of a word occupies for instance e (0 = LE, 1 = BE).
  function automatic int lane(input int e, input int i);
    return (e != 0) ? (3 - i) : i;
  endfunction

  // Commits the current cycle's memory write, then advances to the next
  // negative edge.
  task automatic tick();
    for (int e = 0; e < 2; e++) begin
      if (memwrite_v[e] === 1'b1) mem[e][adr_v[e]] = writedata_v[e];
    end
    @(negedge clk);
  endtask

  // Runs one word transaction on both instances and checks every cycle.
  // If hold=1, req_valid stays high with junk fields after the accept edge.
  // If abort_beat >= 0, reset is asserted during that beat.
  task automatic do_txn(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input bit hold, input int abort_beat);
    logic [31:0] exp_word;
    logic [7:0]  ad;
    tick();
    for (int e = 0; e < 2; e++) begin
      check($sformatf("idle_ready[%0d]", e), ready_v[e], 1);
      check($sformatf("idle_busy[%0d]", e), busy_v[e], 0);
      check($sformatf("idle_resp[%0d]", e), resp_valid_v[e], 0);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        if (hold) begin
          req_write = 1'($urandom);
          req_addr  = 8'($urandom);
          req_wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      ad = a + 8'(i);
      for (int e = 0; e < 2; e++) begin
        check($sformatf("beat%0d_busy[%0d]", i, e), busy_v[e], 1);
        check($sformatf("beat%0d_ready[%0d]", i, e), ready_v[e], 0);
        check($sformatf("beat%0d_resp[%0d]", i, e), resp_valid_v[e], 0);
        check($sformatf("beat%0d_adr[%0d]", i, e), adr_v[e], ad);
        check($sformatf("beat%0d_memwrite[%0d]", i, e), memwrite_v[e], wr);
        if (wr) check($sformatf("beat%0d_wbyte[%0d]", i, e), writedata_v[e], wd[lane(e, i)*8 +: 8]);
      end
      if (i == abort_beat) begin
        #2 reset = 1'b0;
        #1;
        for (int e = 0; e < 2; e++) begin
          check($sformatf("abort_memwrite[%0d]", e), memwrite_v[e], 0);
          check($sformatf("abort_busy[%0d]", e), busy_v[e], 0);
          check($sformatf("abort_adr[%0d]", e), adr_v[e], 0);
          check($sformatf("abort_rdata[%0d]", e), rdata_v[e], 0);
          last_rd[e] = '0;
          if (wr) begin
            for (int j = 0; j < i; j++) ref_mem[e][8'(a + 8'(j))] = wd[lane(e, j)*8 +: 8];
          end
        end
        req_valid = 1'b0;
        tick();
        for (int e = 0; e < 2; e++) check($sformatf("abort_resp[%0d]", e), resp_valid_v[e], 0);
        reset = 1'b1;
        $display("txn %s addr=%02h data=%08h aborted at beat %0d", wr ? "WR" : "RD", a, wd, i);
        return;
      end
    end
    tick();
    for (int e = 0; e < 2; e++) begin
      check($sformatf("done_resp[%0d]", e), resp_valid_v[e], 1);
      check($sformatf("done_busy[%0d]", e), busy_v[e], 0);
      check($sformatf("done_ready[%0d]", e), ready_v[e], 0);
      check($sformatf("done_memwrite[%0d]", e), memwrite_v[e], 0);
      if (wr) begin
        for (int i = 0; i < 4; i++) ref_mem[e][8'(a + 8'(i))] = wd[lane(e, i)*8 +: 8];
      end else begin
        exp_word = '0;
        for (int i = 0; i < 4; i++) exp_word[lane(e, i)*8 +: 8] = ref_mem[e][8'(a + 8'(i))];
        last_rd[e] = exp_word;
      end
      check($sformatf("done_rdata[%0d]", e), rdata_v[e], last_rd[e]);
    end
    $display("txn %s addr=%02h data=%08h rdata_le=%08h rdata_be=%08h hold=%0d",
             wr ? "WR" : "RD", a, wd, rdata_v[0], rdata_v[1], hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h55;
    req_wdata = 32'hDEADBEEF;
    for (int e = 0; e < 2; e++) last_rd[e] = '0;
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom);
      for (int e = 0; e < 2; e++) begin
        mem[e][k]     = b;
        ref_mem[e][k] = b;
      end
    end
    for (int e = 0; e < 2; e++) begin
      mem[e][8'h10] = 8'h00; mem[e][8'h11] = 8'hBF; mem[e][8'h12] = 8'hCC; mem[e][8'h13] = 8'h80;
      ref_mem[e][8'h10] = 8'h00; ref_mem[e][8'h11] = 8'hBF;
      ref_mem[e][8'h12] = 8'hCC; ref_mem[e][8'h13] = 8'h80;
    end

    // Held in reset with a request pending: every output stays at zero.
    repeat (3) begin
      tick();
      for (int e = 0; e < 2; e++) begin
        check($sformatf("rst_ready[%0d]", e), ready_v[e], 0);
        check($sformatf("rst_resp[%0d]", e), resp_valid_v[e], 0);
        check($sformatf("rst_rdata[%0d]", e), rdata_v[e], 0);
        check($sformatf("rst_busy[%0d]", e), busy_v[e], 0);
        check($sformatf("rst_adr[%0d]", e), adr_v[e], 0);
        check($sformatf("rst_memwrite[%0d]", e), memwrite_v[e], 0);
        check($sformatf("rst_wdata[%0d]", e), writedata_v[e], 0);
      end
    end
    reset     = 1'b1;
    req_valid = 1'b0;

    // Directed reads and writes.
    do_txn(1'b0, 8'h10, 32'h0, 1'b0, -1);
    check("le_read_word", rdata_v[0], 32'h80CCBF00);
    check("be_read_word", rdata_v[1], 32'h00BFCC80);
    do_txn(1'b1, 8'h20, 32'hA0776600, 1'b0, -1);
    check("le_write_mem", {mem[0][8'h23], mem[0][8'h22], mem[0][8'h21], mem[0][8'h20]}, 32'hA0776600);
    check("be_write_mem", {mem[1][8'h20], mem[1][8'h21], mem[1][8'h22], mem[1][8'h23]}, 32'hA0776600);
    do_txn(1'b0, 8'h20, 32'h0, 1'b0, -1);
    check("le_readback", rdata_v[0], 32'hA0776600);
    check("be_readback", rdata_v[1], 32'hA0776600);

    // A read that wraps the address, with req_valid held high throughout.
    do_txn(1'b0, 8'hFE, 32'h0, 1'b1, -1);
    do_txn(1'b1, 8'h40, $urandom, 1'b0, -1);

    // Reset during beat 2 of a write, then read the partly written word back.
    do_txn(1'b1, 8'h30, 32'h13579BDF, 1'b0, 2);
    do_txn(1'b0, 8'h30, 32'h0, 1'b0, -1);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 8'($urandom), $urandom,
             (n != 39) && ($urandom_range(0, 3) == 0), -1);
    end
    req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_word_port.md
Name: mem_word_port

Overview:
- Parametrised word-to-byte memory adapter between the multicycle core and its narrow byte-wide memory.
- Replaces the core's hard-wired four-cycle byte fetch and store sequencing.
- Accepts one word read or word write request through a valid/ready handshake, then performs WORD_BYTES consecutive byte accesses on the memory bus.
- Read: assembles the bytes into a word using the selected byte order and returns it with a one-cycle response pulse. Write: sequences the bytes out the same way.

Parameters:
ADDR_WIDTH, 8, byte address width of memory bus and request address
BYTE_WIDTH, 8, width of one memory beat
WORD_BYTES, 4, beats per word (>=1)
BIG_ENDIAN, 0, 0: byte at base+i maps to lane i; 1: maps to lane WORD_BYTES-1-i

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  adapter can accept request
req_write  in  1  1 = word write, 0 = word read
req_addr  in  ADDR_WIDTH  base byte address
req_wdata  in  BYTE_WIDTH*WORD_BYTES  write word
resp_valid  out  1  one-cycle completion pulse (read data valid / write done)
resp_rdata  out  BYTE_WIDTH*WORD_BYTES  assembled read word
busy  out  1  transaction in progress (READ or WRITE state)
adr  out  ADDR_WIDTH  memory byte address
memwrite  out  1  memory write strobe
writedata  out  BYTE_WIDTH  memory write byte
memdata  in  BYTE_WIDTH  memory read byte, combinational from adr in the same cycle

Behaviour:
- Reset (reset=0, async): state IDLE, beat counter 0, req_ready=0 while asserted, resp_valid=0, resp_rdata=0, busy=0, adr=0, memwrite=0, writedata=0. Any in-flight transaction is abandoned; memwrite drops immediately, with no partial completion pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE: req_ready=1. On a rising edge with req_valid=1:
  - Latch req_addr, req_write, req_wdata.
  - Clear the beat counter.
  - Go to WRITE if req_write=1, else READ.
  - Requests while req_ready=0 are ignored, not queued.
- READ: for beat i = 0..WORD_BYTES-1, one beat per cycle:
  - adr = base+i, modulo 2^ADDR_WIDTH (wraps, no error).
  - memdata is captured at that cycle's edge into lane L. L=i if BIG_ENDIAN=0, else WORD_BYTES-1-i. Lane L is bits [L*BYTE_WIDTH +: BYTE_WIDTH].
  - Other lanes hold their values. After the last beat, go to DONE.
- WRITE: for beat i:
  - adr = base+i (wrapping), memwrite=1.
  - writedata = lane L of the latched wdata, same lane mapping as READ.
  - After the last beat, go to DONE. memwrite is 0 in every other state.
- DONE:
  - resp_valid=1 for exactly one cycle. req_ready=0. Next state is IDLE.
  - resp_rdata holds the assembled word after a read. It holds its prior value after a write. It is stable until the next read completes.
- Latency: request accepted at edge k; beats occupy cycles k+1..k+WORD_BYTES; resp_valid in cycle k+WORD_BYTES+1. The earliest next accept is edge k+WORD_BYTES+2.
- busy=1 exactly in READ/WRITE.
- adr holds the last beat address in DONE/IDLE (value irrelevant, but no glitching to X).
- Unaligned base addresses are legal: bytes are taken sequentially from base.
- WORD_BYTES=1: a single beat, then DONE.
- Beat counter width: enough for WORD_BYTES-1, minimum 1 bit.

Test Plan:
- Reset check: hold reset=0 and drive req_valid=1 → all outputs 0, no memwrite. Release → req_ready=1 in the next cycle.
- Little-endian read, defaults: read at 0x10, memory[0x10..0x13] = 00,BF,CC,80 → adr steps 10,11,12,13 over four cycles; resp_valid one cycle later; resp_rdata = 0x80CCBF00.
- BIG_ENDIAN=1 instance, same stimulus → resp_rdata = 0x00BFCC80. Latency is identical (resp_valid 5 cycles after accept).
- Write 0xA0776600 to 0x20 → memwrite=1 for exactly 4 cycles; adr/writedata = 20/00, 21/66, 22/77, 23/A0; then a resp_valid pulse; resp_rdata unchanged.
- Wrap and busy: read at 0xFE with a second req_valid held high throughout → adr FE, FF, 00, 01; the second request is not accepted until the cycle after resp_valid.
- Reset mid-write: assert reset during beat 2 → memwrite falls asynchronously, no resp_valid. After release, a new read completes normally.
